// File: rtl/baud_gen_frac.sv
// Fractional oversample/baud tick generator: oversample period = active_int + active_frac/2^FRAC_W
// clocks, realised by stretching selected intervals by one clock from a fractional accumulator carry.
module baud_gen_frac #(
    parameter int DIV_W            = 16,
    parameter int FRAC_W           = 8,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = 27,
    parameter int DEFAULT_DIV_FRAC = 32,
    localparam int PH_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              baud_tick,
    output logic [PH_W-1:0]   os_phase
);

    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEFAULT_DIV_INT);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_DIV_FRAC);
    localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(2);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]  active_int;
    logic [FRAC_W-1:0] active_frac;
    logic [FRAC_W-1:0] acc;
    logic              extra;
    logic [DIV_W:0]    cnt;

    logic [DIV_W:0]    period_m1;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W-1:0]  load_int;
    logic              ival_end;
    logic              phase_last;

    // active_int is never below 2, so period_m1 cannot underflow
    assign period_m1  = {1'b0, active_int} + {{DIV_W{1'b0}}, extra} - {{DIV_W{1'b0}}, 1'b1};
    assign acc_sum    = {1'b0, acc} + {1'b0, active_frac};
    assign load_int   = (div_int < MIN_INT) ? MIN_INT : div_int;
    assign ival_end   = (cnt == period_m1);
    assign phase_last = (os_phase == PH_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_int  <= DEF_INT;
            active_frac <= DEF_FRAC;
            cnt         <= '0;
            acc         <= '0;
            extra       <= 1'b0;
            os_phase    <= '0;
            os_tick     <= 1'b0;
            baud_tick   <= 1'b0;
        end else if (cfg_load) begin
            active_int  <= load_int;
            active_frac <= div_frac;
            cnt         <= '0;
            acc         <= '0;
            extra       <= 1'b0;
            os_phase    <= '0;
            os_tick     <= 1'b0;
            baud_tick   <= 1'b0;
        end else if (en) begin
            os_tick   <= 1'b0;
            baud_tick <= 1'b0;
            if (ival_end) begin
                cnt       <= '0;
                os_tick   <= 1'b1;
                acc       <= acc_sum[FRAC_W-1:0];
                extra     <= acc_sum[FRAC_W];
                os_phase  <= phase_last ? '0 : os_phase + 1'b1;
                baud_tick <= phase_last;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            os_tick   <= 1'b0;
            baud_tick <= 1'b0;
        end
    end

endmodule
